linebuffer_pingpong: RTL and testbench

Double-buffered, multi-channel line buffer with independent horizontal and vertical integer scaling, sitting between framebuffer read logic and the display output stage. It requests one source line at a time from upstream and fills one bank while the other bank is replayed to the display. It counts source lines per frame, so upstream needs no last-line special cases. It also flags lines that were not fully loaded in time.

---
 rtl/linebuffer_pingpong.sv | 169 ++++++++++++++++
 tb/tb_linebuffer_pingpong.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/linebuffer_pingpong.sv
// Ping-pong line buffer: fills one bank from upstream while replaying the other with X/Y integer scaling.
// Optional macro LINEBUFFER_PINGPONG_UNDERRUN_EN enables the sticky underrun flag (tied 0 when undefined).
module linebuffer_pingpong #(
  parameter int CHANW   = 8,
  parameter int CHANS   = 3,
  parameter int LEN     = 160,
  parameter int SCALE_X = 6,
  parameter int SCALE_Y = 6,
  parameter int LINES   = 120
) (
  input  logic                   clk_pix,
  input  logic                   rst_n,
  input  logic                   frame,
  output logic                   data_req,
  input  logic                   en_in,
  input  logic [CHANS*CHANW-1:0] din,
  input  logic                   en_out,
  output logic [CHANS*CHANW-1:0] dout,
  output logic                   dout_valid,
  output logic                   underrun
);
  localparam int W  = CHANS * CHANW;
  localparam int AW = (LEN > 1) ? $clog2(LEN) : 1;
  localparam int XW = (SCALE_X > 1) ? $clog2(SCALE_X) : 1;
  localparam int YW = (SCALE_Y > 1) ? $clog2(SCALE_Y) : 1;
  localparam int RW = $clog2(LINES + 1);
  localparam int OW = $clog2(LINES * SCALE_Y + 1);

  localparam logic [AW-1:0] A_LAST = AW'(LEN - 1);
  localparam logic [XW-1:0] X_LAST = XW'(SCALE_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SCALE_Y - 1);
  localparam logic [RW-1:0] R_MAX  = RW'(LINES);
  localparam logic [OW-1:0] O_MAX  = OW'(LINES * SCALE_Y);
  localparam logic [OW-1:0] O_LAST = OW'(LINES * SCALE_Y - 1);

  typedef enum logic {W_IDLE, W_FILL} wstate_t;

  wstate_t       wstate;
  logic [W-1:0]  mem [2][LEN];
  logic          wbank, rbank, rd_active;
  logic [1:0]    full;
  logic [AW-1:0] waddr, raddr;
  logic [XW-1:0] xrep;
  logic [YW-1:0] yrep;
  logic [OW-1:0] oline;
  logic [RW-1:0] req_cnt;

  logic wr_beat, fill_done, rd_done, rd_beat, x_wrap, line_done, y_wrap;
  logic last_line, other_full, can_req;

  always_comb begin
    wr_beat    = !frame && (wstate == W_FILL) && en_in;
    fill_done  = wr_beat && (waddr == A_LAST);
    rd_done    = (oline == O_MAX);
    rd_beat    = !frame && en_out && rd_active && !rd_done;
    x_wrap     = (xrep == X_LAST);
    line_done  = rd_beat && x_wrap && (raddr == A_LAST);
    y_wrap     = (yrep == Y_LAST);
    last_line  = (oline == O_LAST);
    // A fill landing in the same cycle counts as complete for the swap check
    other_full = full[~rbank] || (fill_done && (wbank != rbank));
    can_req    = (req_cnt < R_MAX);
  end

  always_ff @(posedge clk_pix) begin
    if (rst_n && wr_beat) mem[wbank][waddr] <= din;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n) begin
      wstate     <= W_IDLE;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      rd_active  <= 1'b0;
      full       <= '0;
      waddr      <= '0;
      raddr      <= '0;
      xrep       <= '0;
      yrep       <= '0;
      oline      <= '0;
      req_cnt    <= '0;
      data_req   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else if (frame) begin
      wstate     <= W_FILL;
      wbank      <= 1'b0;
      rbank      <= 1'b0;
      rd_active  <= 1'b0;
      full       <= '0;
      waddr      <= '0;
      raddr      <= '0;
      xrep       <= '0;
      yrep       <= '0;
      oline      <= '0;
      req_cnt    <= RW'(1);
      data_req   <= 1'b1;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      data_req   <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;

      if (wr_beat) begin
        waddr <= waddr + 1'b1;
        if (fill_done) begin
          full[wbank] <= 1'b1;
          wstate      <= W_IDLE;
          waddr       <= '0;
        end
      end

      // Start of frame: first completed bank goes straight to replay
      if (!rd_active && (wstate == W_IDLE) && full[wbank]) begin
        rd_active <= 1'b1;
        rbank     <= wbank;
        if (can_req) begin
          data_req <= 1'b1;
          req_cnt  <= req_cnt + RW'(1);
          wbank    <= ~wbank;
          wstate   <= W_FILL;
          waddr    <= '0;
        end
      end

      if (rd_beat) begin
        dout       <= mem[rbank][raddr];
        dout_valid <= 1'b1;
        xrep       <= x_wrap ? '0 : xrep + 1'b1;
        if (x_wrap) raddr <= (raddr == A_LAST) ? '0 : raddr + 1'b1;
        if (line_done) begin
          oline <= oline + 1'b1;
          yrep  <= y_wrap ? '0 : yrep + 1'b1;
          if (y_wrap) begin
            full[rbank] <= 1'b0;
            if (!last_line) begin
              rbank <= ~rbank;
              if (other_full && can_req) begin
                data_req <= 1'b1;
                req_cnt  <= req_cnt + RW'(1);
                wbank    <= rbank;
                wstate   <= W_FILL;
                waddr    <= '0;
              end
            end
          end
        end
      end
    end
  end

`ifdef LINEBUFFER_PINGPONG_UNDERRUN_EN
  logic underrun_set;

  always_comb begin
    underrun_set = line_done && y_wrap && !last_line && !other_full;
  end

  always_ff @(posedge clk_pix) begin
    if (!rst_n)            underrun <= 1'b0;
    else if (frame)        underrun <= 1'b0;
    else if (underrun_set) underrun <= 1'b1;
  end
`else
  assign underrun = 1'b0;
`endif

endmodule

// File: tb/tb_linebuffer_pingpong.sv
// Directed/randomized bench for linebuffer_pingpong; expected pixels come from a source-line array model.
module tb_linebuffer_pingpong;
  localparam int CHANW = 8;
  localparam int CHANS = 1;
  localparam int LEN   = 4;
  localparam int SX    = 2;
  localparam int SY    = 2;
  localparam int LINES = 3;
  localparam int W     = CHANW * CHANS;
  localparam int TOTAL = LINES * SY * LEN * SX;

`ifdef LINEBUFFER_PINGPONG_UNDERRUN_EN
  localparam logic UR_EXP = 1'b1;
`else
  localparam logic UR_EXP = 1'b0;
`endif

  logic         clk_pix = 1'b0;
  logic         rst_n   = 1'b0;
  logic         frame   = 1'b0;
  logic         en_in   = 1'b0;
  logic         en_out  = 1'b0;
  logic [W-1:0] din     = '0;
  logic         data_req, dout_valid, underrun;
  logic [W-1:0] dout;

  int checks     = 0;
  int failures   = 0;
  int req_pulses = 0;
  int ocnt       = 0;
  int src [LINES][LEN];

  linebuffer_pingpong #(
    .CHANW(CHANW), .CHANS(CHANS), .LEN(LEN),
    .SCALE_X(SX), .SCALE_Y(SY), .LINES(LINES)
  ) dut (
    .clk_pix(clk_pix), .rst_n(rst_n), .frame(frame), .data_req(data_req),
    .en_in(en_in), .din(din), .en_out(en_out), .dout(dout),
    .dout_valid(dout_valid), .underrun(underrun)
  );

  always #5 clk_pix = ~clk_pix;

  always @(posedge clk_pix) if (data_req === 1'b1) req_pulses++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_pix);
    #1;
  endtask

  // Output pixel k of the frame: source line k/(LEN*SX*SY), pixel (k mod LEN*SX)/SX
  function automatic logic [W-1:0] exp_px(input int k);
    int oline, sline, px;
    oline = k / (LEN * SX);
    sline = oline / SY;
    px    = (k % (LEN * SX)) / SX;
    return W'(src[sline][px]);
  endfunction

  task automatic fill_src(input bit counting);
    for (int l = 0; l < LINES; l++)
      for (int p = 0; p < LEN; p++)
        src[l][p] = counting ? (l * LEN + p + 1) : int'($urandom_range(255, 0));
  endtask

  task automatic pulse_frame();
    frame = 1'b1;
    tick();
    frame = 1'b0;
    en_in = 1'b0;
    check("frame_req", {31'b0, data_req}, 32'd1);
  endtask

  task automatic send_line(input int l, input bit gapped);
    for (int p = 0; p < LEN; p++) begin
      if (gapped) begin
        repeat ($urandom_range(2, 0)) begin
          en_in = 1'b0;
          din   = W'($urandom);
          tick();
        end
      end
      en_in = 1'b1;
      din   = W'(src[l][p]);
      tick();
    end
    en_in = 1'b0;
    din   = '0;
  endtask

  task automatic wait_req(input string tag);
    int n;
    n = 0;
    while (data_req !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, {31'b0, data_req}, 32'd1);
  endtask

  task automatic read_pixels(input int n, input bit gapped);
    int  beats, guard;
    logic e;
    beats = 0;
    guard = 0;
    while (beats < n && guard < 1000) begin
      e = gapped ? 1'($urandom_range(1, 0)) : 1'b1;
      en_out = e;
      tick();
      guard++;
      if (e && ocnt < TOTAL) begin
        check("dout", {24'b0, dout}, {24'b0, exp_px(ocnt)});
        check("dout_valid", {31'b0, dout_valid}, 32'd1);
      end else begin
        check("dout_idle", {24'b0, dout}, 32'd0);
        check("dout_valid_idle", {31'b0, dout_valid}, 32'd0);
      end
      if (e) begin
        ocnt++;
        beats++;
      end
    end
    en_out = 1'b0;
    check("read_budget", beats, n);
  endtask

  task automatic run_frame(input bit gapped);
    int base;
    fill_src(!gapped);
    base = req_pulses;
    pulse_frame();
    send_line(0, gapped);
    check("prefill_gap", {31'b0, data_req}, 32'd0);
    tick();
    check("prefill_req", {31'b0, data_req}, 32'd1);
    send_line(1, gapped);
    ocnt = 0;
    read_pixels(2 * LEN * SX, gapped);
    check("third_req", {31'b0, data_req}, 32'd1);
    send_line(2, gapped);
    read_pixels(2 * LEN * SX, gapped);
    check("no_fourth_req", {31'b0, data_req}, 32'd0);
    read_pixels(2 * LEN * SX, gapped);
    read_pixels(LEN * SX, gapped);
    repeat (3) tick();
    check("req_total", req_pulses - base, 3);
    check("no_underrun", {31'b0, underrun}, 32'd0);
  endtask

  initial begin
    // Reset with random inputs, including frame
    tick();
    repeat (3) begin
      frame  = 1'($urandom_range(1, 0));
      en_in  = 1'($urandom_range(1, 0));
      en_out = 1'($urandom_range(1, 0));
      din    = W'($urandom);
      tick();
      check("rst_data_req", {31'b0, data_req}, 32'd0);
      check("rst_dout", {24'b0, dout}, 32'd0);
      check("rst_dout_valid", {31'b0, dout_valid}, 32'd0);
      check("rst_underrun", {31'b0, underrun}, 32'd0);
    end
    frame = 1'b0;
    rst_n = 1'b1;
    repeat (4) begin
      en_in  = 1'($urandom_range(1, 0));
      en_out = 1'($urandom_range(1, 0));
      din    = W'($urandom);
      tick();
      check("idle_no_req", {31'b0, data_req}, 32'd0);
      check("idle_no_valid", {31'b0, dout_valid}, 32'd0);
    end
    en_in  = 1'b0;
    en_out = 1'b0;

    run_frame(1'b0);
    run_frame(1'b1);

    // Underrun: second line never delivered
    fill_src(1'b0);
    pulse_frame();
    send_line(0, 1'b0);
    wait_req("ur_req2");
    ocnt = 0;
    read_pixels(2 * LEN * SX - 1, 1'b0);
    check("ur_before", {31'b0, underrun}, 32'd0);
    read_pixels(1, 1'b0);
    check("ur_set", {31'b0, underrun}, {31'b0, UR_EXP});
    repeat (3) tick();
    check("ur_sticky", {31'b0, underrun}, {31'b0, UR_EXP});

    // Abort mid-fill; frame cycle also carries a beat that must be dropped
    pulse_frame();
    check("ur_cleared", {31'b0, underrun}, 32'd0);
    en_in = 1'b1; din = 8'hAA; tick();
    en_in = 1'b1; din = 8'hBB; tick();
    din = 8'hCC;
    pulse_frame();
    fill_src(1'b0);
    send_line(0, 1'b0);
    wait_req("abort_req2");
    send_line(1, 1'b0);
    ocnt = 0;
    read_pixels(3 * LEN * SX, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
